// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: op encoding,
// FSM states, datapath step mode and a conditional negate helper.
package muldiv_pkg;

  // Widest intermediate the negate helper handles (2 * max supported WIDTH).
  localparam int unsigned NEG_W = 128;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  typedef enum logic {
    M_MUL,
    M_DIV
  } step_mode_e;

  // Two's-complement negate when neg is set; callers zero-extend into
  // NEG_W and truncate back, which is exact modulo 2^n.
  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] x,
                                                 input logic             neg);
    return neg ? (~x + NEG_W'(1)) : x;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the mul/div unit.
//   start/op/cancel/a/b : request side (driven by the pipeline)
//   busy/done/div_by_zero/hi/lo : status and architectural HI/LO
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, cancel, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, cancel, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath (purely combinational).
//   acc        : {upper half, lower half}; lower half holds multiplier or
//                dividend bits being consumed, upper half the partial result
//   opnd       : multiplicand / divisor magnitude
//   mode       : M_MUL shift-add, M_DIV restoring shift-subtract
//   acc_next_c : accumulator after this iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  step_mode_e         mode,
  output logic [2*WIDTH-1:0] acc_next_c
);
  localparam int unsigned AW = 2 * WIDTH;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum        = '0;
    rem_sh     = '0;
    diff       = '0;
    acc_next_c = acc;
    if (mode == M_MUL) begin
      // Add multiplicand into the upper half when the LSB multiplier bit is set,
      // then shift the whole accumulator right, keeping the carry.
      sum        = {1'b0, acc[AW-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
      acc_next_c = {sum, acc[WIDTH-1:1]};
    end else begin
      // Shift next dividend bit into the remainder (one extra bit of headroom)
      // and subtract the divisor if it fits; quotient bit enters at the LSB.
      rem_sh = acc[AW-1:WIDTH-1];
      diff   = rem_sh - {1'b0, opnd};
      if (rem_sh >= {1'b0, opnd}) begin
        acc_next_c = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_c = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//   clk, rst_n : clock, async active-low reset
//   bus        : muldiv_if slave (start/op/cancel/a/b in; busy/done/
//                div_by_zero/hi/lo out, all registered)
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles (RUN x WIDTH, FIX x 1);
// MTHI/MTLO write in a single cycle from IDLE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  localparam int unsigned AW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  step_mode_e       mode_q, mode_d;
  logic             neg_q, neg_d;     // product / quotient sign
  logic             rneg_q, rneg_d;   // remainder sign (dividend sign)
  logic             dbz_q, dbz_d;     // divide by zero seen at start
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_out_q, dbz_out_d;

  logic [AW-1:0]    acc_next_c;
  logic             is_signed;
  logic             is_div;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [AW-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc_q),
    .opnd       (opnd_q),
    .mode       (mode_q),
    .acc_next_c (acc_next_c)
  );

  // Operand conditioning and sign-corrected results.
  always_comb begin
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    is_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    abs_a     = WIDTH'(cond_neg(NEG_W'(bus.a), is_signed && bus.a[WIDTH-1]));
    abs_b     = WIDTH'(cond_neg(NEG_W'(bus.b), is_signed && bus.b[WIDTH-1]));
    prod      = AW'(cond_neg(NEG_W'(acc_q), neg_q));
    quo       = WIDTH'(cond_neg(NEG_W'(acc_q[WIDTH-1:0]), neg_q));
    rem       = WIDTH'(cond_neg(NEG_W'(acc_q[AW-1:WIDTH]), rneg_q));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    mode_d    = mode_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d = S_RUN;
              cnt_d   = CNT_W'(WIDTH - 1);
              acc_d   = {{WIDTH{1'b0}}, abs_a};
              opnd_d  = abs_b;
              mode_d  = is_div ? M_DIV : M_MUL;
              neg_d   = is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              rneg_d  = is_signed && bus.a[WIDTH-1];
              dbz_d   = is_div && (bus.b == '0);
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_next_c;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.cancel) begin
          done_d    = 1'b1;
          dbz_out_d = dbz_q;
          if (mode_q == M_MUL) begin
            hi_d = prod[AW-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else begin
            // Divide by zero: magnitude path leaves |a| as remainder, which the
            // dividend-sign correction turns back into a; quotient forced to ones.
            hi_d = rem;
            lo_d = dbz_q ? '1 : quo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      mode_q    <= M_MUL;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      mode_q    <= mode_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_out_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
